// File: rtl/pipe_chain.sv
// Elastic register chain: DEPTH stages of WIDTH-bit payload with valid/ready
// backpressure, global flush, per-stage kill and a fence/drain mode.

module pipe_chain_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_load,
   input  logic             i_drop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);
   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Emptied stages are zeroed so a stale payload reads as a NOP.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_drop) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
endmodule

module pipe_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic [DEPTH-1:0] kill,
   input  logic             fence,
   output logic             fence_done,
   output logic [CW-1:0]    occupancy
);
   logic [DEPTH-1:0]            w_valid;
   logic [DEPTH-1:0][WIDTH-1:0] w_data;
   logic [DEPTH-1:0][WIDTH-1:0] w_src;
   logic [DEPTH-1:0]            w_live;
   logic [DEPTH-1:0]            w_rdy;
   logic [DEPTH-1:0]            w_load;
   logic [DEPTH-1:0]            w_nvalid;
   logic [CW-1:0]               w_cnt;
   logic                        w_in_ready;
   logic [CW-1:0]               r_occ;

   // Readiness ripples from the output back to the input so a full chain
   // restarts without a bubble when out_ready rises.
   always_comb begin
      w_live     = w_valid & ~kill & {DEPTH{~flush}};
      w_rdy      = '0;
      w_load     = '0;
      w_src      = '0;
      w_nvalid   = '0;
      w_cnt      = '0;
      w_rdy[DEPTH-1] = ~w_live[DEPTH-1] | out_ready;
      for (int i = DEPTH-2; i >= 0; i--)
         w_rdy[i] = ~w_live[i] | w_rdy[i+1];
      w_in_ready = w_rdy[0] & ~fence & ~flush;
      w_load[0]  = in_valid & w_in_ready;
      w_src[0]   = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_load[i] = w_rdy[i] & w_live[i-1];
         w_src[i]  = w_data[i-1];
      end
      // A stage that is not ready must be holding a live entry.
      for (int i = 0; i < DEPTH; i++) begin
         w_nvalid[i] = ~flush & (w_load[i] | (~w_rdy[i] & w_valid[i]));
         w_cnt       = w_cnt + CW'(w_nvalid[i]);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_flush (flush),
         .i_load  (w_load[g]),
         .i_drop  (w_rdy[g]),
         .i_data  (w_src[g]),
         .o_valid (w_valid[g]),
         .o_data  (w_data[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) r_occ <= '0;
      else     r_occ <= w_cnt;
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_live[DEPTH-1];
   assign out_data   = w_data[DEPTH-1];
   assign occupancy  = r_occ;
   assign fence_done = fence & (r_occ == '0) & ~|w_valid;
endmodule
